// File: rtl/bch_decode_arbiter.sv
// Round-robin owner of one shared BCH decode pipeline; tags each codeword's channel in an in-flight FIFO.
// Define BCH_DECODE_ARB_STATS_EN to add the per-channel done_count output.
module bch_decode_arbiter #(
  parameter int NCH   = 4,
  parameter int BITS  = 1,
  parameter int BEATS = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*BITS-1:0]    data_in,
  output logic [NCH-1:0]         grant,
  output logic                   beat_take,
  output logic                   syn_start,
  input  logic                   syn_ready,
  input  logic                   ce,
  output logic [BITS-1:0]        syn_data,
  input  logic                   err_first,
  input  logic                   err_last,
  output logic [$clog2(NCH)-1:0] err_tag,
  output logic                   err_tag_valid,
  output logic                   orphan
`ifdef BCH_DECODE_ARB_STATS_EN
  ,
  output logic [NCH*16-1:0]      done_count
`endif
);

  localparam int TW = $clog2(NCH);
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [TW-1:0]   last_q, last_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            push_q, push_d;
  logic [TW-1:0]   push_tag_q, push_tag_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            orphan_q, orphan_d;
  logic [TW-1:0]   mem_q [DEPTH];

  logic [TW-1:0]   winner, rr_sel;
  logic            found, fifo_full, fifo_empty, pop;

  // Search starts one past the last owner so every requester is served in turn.
  always_comb begin
    winner = '0;
    rr_sel = '0;
    found  = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      rr_sel = TW'((int'(last_q) + k) % NCH);
      if (!found && req[rr_sel]) begin
        found  = 1'b1;
        winner = rr_sel;
      end
    end
  end

  // The tag is written one cycle after the grant, so a pending push counts toward full.
  assign fifo_full  = (int'(cnt_q) + int'(push_q)) >= DEPTH;
  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_d     = beat_q;
    push_d     = 1'b0;
    push_tag_d = push_tag_q;
    beat_take  = 1'b0;
    syn_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full && syn_ready && ce) begin
          state_d         = STREAM;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          last_d          = winner;
          beat_d          = '0;
          push_d          = 1'b1;
          push_tag_d      = winner;
        end
      end
      STREAM: begin
        beat_take = ce;
        syn_start = ce && (beat_q == '0);
        if (ce) begin
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    syn_data = '0;
    for (int i = 0; i < NCH; i++)
      if (grant_q[i]) syn_data = data_in[i*BITS +: BITS];
  end

  always_comb begin
    pop      = err_last && !fifo_empty;
    wr_d     = push_q ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q;
    if (push_q && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_q && pop) cnt_d = cnt_q - 1'b1;
    orphan_d = orphan_q | ((err_first | err_last) & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= TW'(NCH - 1);
      beat_q     <= '0;
      push_q     <= 1'b0;
      push_tag_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      push_q     <= push_d;
      push_tag_q <= push_tag_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      orphan_q   <= orphan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) mem_q[wr_q] <= push_tag_q;
  end

  assign grant         = grant_q;
  assign err_tag_valid = !fifo_empty;
  assign err_tag       = fifo_empty ? '0 : mem_q[rd_q];
  assign orphan        = orphan_q;

`ifdef BCH_DECODE_ARB_STATS_EN
  logic [NCH-1:0][15:0] done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (pop && done_q[err_tag] != 16'hFFFF) done_d[err_tag] = done_q[err_tag] + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= '0;
    else       done_q <= done_d;
  end

  assign done_count = done_q;
`endif

endmodule

// File: tb/tb_bch_decode_arbiter.sv
// Bench for bch_decode_arbiter: directed sequences plus random traffic against a queue-based reference model.
module tb_bch_decode_arbiter;
  localparam int NCH = 4, BITS = 2, BEATS = 8, DEPTH = 4, TW = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NCH-1:0]      req = '0;
  logic [NCH*BITS-1:0] data_in = '0;
  logic                syn_ready = 1'b1, ce = 1'b1, err_first = 1'b0, err_last = 1'b0;
  logic [NCH-1:0]      grant;
  logic                beat_take, syn_start, err_tag_valid, orphan;
  logic [BITS-1:0]     syn_data;
  logic [TW-1:0]       err_tag;
`ifdef BCH_DECODE_ARB_STATS_EN
  logic [NCH*16-1:0]   done_count;
`endif

  int   n_cmp = 0, n_bad = 0;
  logic auto_pop = 1'b0, man_last = 1'b0;
  int   ng, ns, nr, j, pos, cw;
  logic [NCH-1:0] eg, prevg;
  logic [31:0] r;

  bch_decode_arbiter #(.NCH(NCH), .BITS(BITS), .BEATS(BEATS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .beat_take(beat_take), .syn_start(syn_start), .syn_ready(syn_ready), .ce(ce),
    .syn_data(syn_data), .err_first(err_first), .err_last(err_last), .err_tag(err_tag),
    .err_tag_valid(err_tag_valid), .orphan(orphan)
`ifdef BCH_DECODE_ARB_STATS_EN
    , .done_count(done_count)
`endif
  );

  always #5 clk = ~clk;

  // Decoder stand-in: either retire each tag as soon as it appears, or follow man_last.
  always @(negedge clk) err_last <= auto_pop ? err_tag_valid : man_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner + beats consumed, tag queue with one-cycle delayed push.
  bit m_busy, m_orphan, m_start, m_empty;
  int m_owner, m_beats, m_last, m_pend, m_win, m_i;
  int m_q[$];
  int m_done[NCH];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_last = NCH - 1; m_pend = -1;
      m_q.delete(); m_orphan = 0;
      for (int i = 0; i < NCH; i++) m_done[i] = 0;
    end else begin
      m_win = -1;
      for (int k = 1; k <= NCH; k++) begin
        m_i = (m_last + k) % NCH;
        if (m_win < 0 && req[m_i]) m_win = m_i;
      end
      m_start = !m_busy && m_win >= 0 && (m_q.size() + (m_pend >= 0 ? 1 : 0)) < DEPTH
                && syn_ready && ce;
      m_empty = (m_q.size() == 0);
      if ((err_first || err_last) && m_empty) m_orphan = 1;
      if (err_last && !m_empty) begin
        if (m_done[m_q[0]] < 65535) m_done[m_q[0]]++;
        void'(m_q.pop_front());
      end
      if (m_pend >= 0) m_q.push_back(m_pend);
      m_pend = -1;
      if (m_busy) begin
        if (ce) begin
          m_beats++;
          if (m_beats == BEATS) m_busy = 0;
        end
      end else if (m_start) begin
        m_busy = 1; m_owner = m_win; m_last = m_win; m_beats = 0; m_pend = m_win;
      end
    end
  end

  logic [NCH-1:0] m_eg;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_eg = '0;
      if (m_busy) m_eg[m_owner] = 1'b1;
      chk("m_grant", grant, m_eg);
      chk("m_take", beat_take, m_busy && ce);
      chk("m_start", syn_start, m_busy && ce && m_beats == 0);
      chk("m_data", syn_data, m_busy ? data_in[m_owner*BITS +: BITS] : '0);
      chk("m_tvalid", err_tag_valid, m_q.size() != 0);
      chk("m_tag", err_tag, m_q.size() != 0 ? m_q[0] : 0);
      chk("m_orphan", orphan, m_orphan);
`ifdef BCH_DECODE_ARB_STATS_EN
      for (int i = 0; i < NCH; i++) chk("m_done", done_count[16*i +: 16], m_done[i]);
`endif
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1; req = '0; ce = 1'b1; syn_ready = 1'b1; err_first = 1'b0;
    man_last = 1'b0; auto_pop = 1'b0; data_in = '1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_take", beat_take, 0);
    chk("rst_start", syn_start, 0);
    chk("rst_data", syn_data, 0);
    chk("rst_tag", err_tag, 0);
    chk("rst_tvalid", err_tag_valid, 0);
    chk("rst_orphan", orphan, 0);
`ifdef BCH_DECODE_ARB_STATS_EN
    for (int i = 0; i < NCH; i++) chk("rst_done", done_count[16*i +: 16], 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [NCH-1:0] exp, input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (grant == exp) got = 1;
    end
    chk(nm, got, 1);
  endtask

  typedef struct {
    logic [NCH-1:0] rq;
    int             win;
  } arb_vec_t;
  arb_vec_t tv[9];

  initial begin
    tv[0] = '{4'b1111, 0}; tv[1] = '{4'b1111, 1}; tv[2] = '{4'b0001, 0};
    tv[3] = '{4'b1010, 1}; tv[4] = '{4'b1001, 3}; tv[5] = '{4'b0110, 1};
    tv[6] = '{4'b0100, 2}; tv[7] = '{4'b1111, 3}; tv[8] = '{4'b1111, 0};

    // Table: each record is one codeword; winner, length and single start pulse.
    do_reset();
    auto_pop = 1'b1;
    for (int t = 0; t < 9; t++) begin
      req = tv[t].rq;
      eg = '0;
      eg[tv[t].win] = 1'b1;
      wait_grant(eg, "tbl_grant_seen");
      chk("tbl_winner", grant, eg);
      ng = 0; ns = 0;
      for (int k = 0; k < 20 && grant == eg; k++) begin
        ng++;
        if (syn_start) ns++;
        cyc();
        req = '0;
        @(negedge clk);
      end
      chk("tbl_len", ng, BEATS);
      chk("tbl_starts", ns, 1);
      cyc();
    end

    // All requesting: 0,1,2,3,0 with 8 grant cycles and one idle cycle each.
    do_reset();
    auto_pop = 1'b1;
    req = '1;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      eg = '0;
      pos = 8;
      if (i > 0) begin
        j = i - 1; pos = j % 9; cw = j / 9;
        if (pos < 8) eg[cw % 4] = 1'b1;
      end
      chk("rr_grant", grant, eg);
      chk("rr_start", syn_start, (i > 0) && pos == 0);
    end

    // Channel 2 alone, ce alternating; req dropped after grant must not abort.
    do_reset();
    auto_pop = 1'b1;
    req = 4'b0100;
    ng = 0; ns = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (grant == 4'b0100) ng++;
      if (syn_start) ns++;
      chk("ce_start_gated", syn_start & ~ce, 0);
      cyc();
      req = (k == 0) ? 4'b0100 : 4'b0000;
      ce = (k % 2 == 1);
    end
    chk("ce_grant_len", ng, 16);
    chk("ce_starts", ns, 1);
    ce = 1'b1;

    // FIFO full: four codewords, then one pop lets a fifth through.
    do_reset();
    req = '1;
    nr = 0; prevg = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (grant != '0 && prevg == '0) nr++;
      prevg = grant;
      cyc();
    end
    chk("full_grants", nr, 4);
    @(negedge clk);
    chk("full_idle", grant, 0);
    chk("full_tvalid", err_tag_valid, 1);
    chk("full_head", err_tag, 0);
    cyc();
    man_last = 1'b1;
    cyc();
    man_last = 1'b0;
    wait_grant(4'b0001, "full_fifth_grant");
    chk("full_head_after_pop", err_tag, 1);

    // Channels 1 then 3 in flight; two pops retire them in order.
    do_reset();
    req = 4'b0010;
    wait_grant(4'b0010, "tag_grant1");
    cyc();
    req = 4'b1000;
    wait_grant(4'b1000, "tag_grant3");
    cyc();
    req = '0;
    @(negedge clk);
    chk("tag_head1", err_tag, 1);
    chk("tag_valid2", err_tag_valid, 1);
    cyc();
    man_last = 1'b1;
    cyc();
    man_last = 1'b0;
    @(negedge clk);
    chk("tag_head3", err_tag, 3);
    chk("tag_valid1", err_tag_valid, 1);
    cyc();
    man_last = 1'b1;
    cyc();
    man_last = 1'b0;
    @(negedge clk);
    chk("tag_empty", err_tag_valid, 0);

    // Orphan: err_first with nothing in flight is sticky.
    do_reset();
    err_first = 1'b1;
    cyc();
    err_first = 1'b0;
    @(negedge clk);
    chk("orphan_set", orphan, 1);
    repeat (5) cyc();
    @(negedge clk);
    chk("orphan_sticky", orphan, 1);

    // Reset at beat 4 clears everything at once; channel 0 wins afterwards.
    do_reset();
    req = 4'b0100;
    wait_grant(4'b0100, "mid_grant");
    req = '0;
    repeat (4) cyc();
    chk("mid_data_live", syn_data, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("mid_grant_clr", grant, 0);
    chk("mid_take_clr", beat_take, 0);
    chk("mid_start_clr", syn_start, 0);
    chk("mid_data_clr", syn_data, 0);
    chk("mid_tag_clr", err_tag, 0);
    chk("mid_tvalid_clr", err_tag_valid, 0);
    chk("mid_orphan_clr", orphan, 0);
`ifdef BCH_DECODE_ARB_STATS_EN
    for (int i = 0; i < NCH; i++) chk("mid_done_clr", done_count[16*i +: 16], 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    req = '1;
    wait_grant(4'b0001, "mid_ch0_first");

    // Random traffic against the model, with one asynchronous reset pulse midway.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      cyc();
      r = $urandom;
      data_in   = r[NCH*BITS-1:0];
      req       = r[NCH*BITS+NCH-1:NCH*BITS];
      ce        = ($urandom_range(0, 3) != 0);
      syn_ready = ($urandom_range(0, 7) != 0);
      man_last  = ($urandom_range(0, 9) < 2);
      err_first = ($urandom_range(0, 199) == 0);
      if (k == 1000) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
